// File: rtl/chip8_pkg.sv
// chip8_pkg: shared scheduler state encoding and timer width for the CHIP-8 core
package chip8_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} sched_state_t;
  localparam int TIMER_W = 8;
endpackage

// File: rtl/rate_divider.sv
// rate_divider: free-running modulo-DIV counter emitting a 1-cycle tick on its last count
module rate_divider #(
  parameter int DIV = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_out = cnt_q == W'(DIV - 1);
  always_comb cnt_d = tick_out ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_in) cnt_q <= rst_in ? '0 : cnt_d;
endmodule

// File: rtl/chip8_exec_sched.sv
// chip8_exec_sched: paces CPU execute starts (run/step), owns delay/sound timers, watchdogs hung instructions
module chip8_exec_sched
  import chip8_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int IPS      = 700,
  parameter int TIMER_HZ = 60,
  parameter int WDOG_CYC = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               run_in,
  input  logic               step_in,
  input  logic               exec_ready_in,
  output logic               exec_start_out,
  input  logic               exec_done_in,
  input  logic               tmr_wr_in,
  input  logic               tmr_sel_in,
  input  logic [TIMER_W-1:0] tmr_data_in,
  output logic [TIMER_W-1:0] delay_out,
  output logic [TIMER_W-1:0] sound_out,
  output logic               beep_out,
  output logic               tick60_out,
  output logic               busy_out,
  output logic               wdog_err_out
);
  localparam int WW = $clog2(WDOG_CYC);
  sched_state_t state_q, state_d;
  logic ips_tick, issue, dec;
  logic ips_pend_q, ips_pend_d, step_pend_q, step_pend_d, err_q, err_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [TIMER_W-1:0] delay_q, delay_d, sound_q, sound_d;
  rate_divider #(.DIV(CLK_HZ / IPS)) u_ips (.clk_in(clk_in), .rst_in(rst_in), .tick_out(ips_tick));
  rate_divider #(.DIV(CLK_HZ / TIMER_HZ)) u_t60 (.clk_in(clk_in), .rst_in(rst_in), .tick_out(tick60_out));
  assign issue = state_q == S_IDLE && exec_ready_in && (ips_pend_q || step_pend_q);
  assign dec = tick60_out && run_in;
  always_comb begin
    state_d = state_q;
    wdog_d = '0;
    err_d = err_q;
    case (state_q)
      S_IDLE:  state_d = issue ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = exec_done_in ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (exec_done_in) state_d = S_IDLE;
        else if (wdog_q == WW'(WDOG_CYC - 1)) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end else wdog_d = wdog_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // A new event arriving on the consuming cycle is kept, so it is issued next time round.
  assign ips_pend_d = run_in && ((ips_pend_q && !issue) || ips_tick);
  assign step_pend_d = !run_in && ((step_pend_q && !issue) || step_in);
  assign delay_d = (tmr_wr_in && !tmr_sel_in) ? tmr_data_in
                 : (dec && delay_q != '0) ? delay_q - 1'b1 : delay_q;
  assign sound_d = (tmr_wr_in && tmr_sel_in) ? tmr_data_in
                 : (dec && sound_q != '0) ? sound_q - 1'b1 : sound_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      ips_pend_q <= 1'b0;
      step_pend_q <= 1'b0;
      err_q <= 1'b0;
      wdog_q <= '0;
      delay_q <= '0;
      sound_q <= '0;
    end else begin
      state_q <= state_d;
      ips_pend_q <= ips_pend_d;
      step_pend_q <= step_pend_d;
      err_q <= err_d;
      wdog_q <= wdog_d;
      delay_q <= delay_d;
      sound_q <= sound_d;
    end
  end
  assign exec_start_out = state_q == S_ISSUE;
  assign busy_out = state_q != S_IDLE;
  assign delay_out = delay_q;
  assign sound_out = sound_q;
  assign beep_out = sound_q != '0;
  assign wdog_err_out = err_q;
endmodule

// File: tb/tb_chip8_exec_sched.sv
// tb_chip8_exec_sched: scoreboard bench for issue pacing, step mode, timers, watchdog and reset
module tb_chip8_exec_sched;
  localparam int CLK_HZ = 1000, IPS = 100, TIMER_HZ = 10, WDOG_CYC = 16;
  logic clk = 0, rst_in = 1, run_in = 1, step_in = 0, exec_ready_in = 1, exec_done_in = 0;
  logic tmr_wr_in = 0, tmr_sel_in = 0;
  logic [7:0] tmr_data_in = 0;
  logic exec_start_out, beep_out, tick60_out, busy_out, wdog_err_out;
  logic [7:0] delay_out, sound_out;
  int pass_cnt = 0, total_cnt = 0, cyc = 0, done_cnt = 0, e;
  bit auto_done = 1;
  int exp_q[$], exp_d[$], exp_b[$];

  chip8_exec_sched #(.CLK_HZ(CLK_HZ), .IPS(IPS), .TIMER_HZ(TIMER_HZ), .WDOG_CYC(WDOG_CYC)) dut (
    .clk_in(clk), .rst_in(rst_in), .run_in(run_in), .step_in(step_in),
    .exec_ready_in(exec_ready_in), .exec_start_out(exec_start_out), .exec_done_in(exec_done_in),
    .tmr_wr_in(tmr_wr_in), .tmr_sel_in(tmr_sel_in), .tmr_data_in(tmr_data_in),
    .delay_out(delay_out), .sound_out(sound_out), .beep_out(beep_out), .tick60_out(tick60_out),
    .busy_out(busy_out), .wdog_err_out(wdog_err_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_in ? 0 : cyc + 1;

  // CPU stand-in: retires each instruction 3 cycles after its start pulse
  always @(negedge clk) begin
    exec_done_in = 0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) exec_done_in = 1;
    end
    if (exec_start_out && auto_done) done_cnt = 3;
  end

  task automatic test_reset();
    rst_in = 1; run_in = 1;
    repeat (3) @(negedge clk);
    total_cnt++; if (exec_start_out !== 1'b0) $display("FAIL reset_start: got %b want 0", exec_start_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else pass_cnt++;
    total_cnt++; if ({delay_out, sound_out} !== 16'h0) $display("FAIL reset_timers: got %h/%h want 0/0", delay_out, sound_out); else pass_cnt++;
    total_cnt++; if ({beep_out, tick60_out, wdog_err_out} !== 3'b0) $display("FAIL reset_flags: got %b want 000", {beep_out, tick60_out, wdog_err_out}); else pass_cnt++;
    rst_in = 0;
  endtask

  task automatic test_run();
    exp_q = '{11, 21, 31, 41};
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (exec_start_out) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL run_start: start at cyc %0d want none", cyc);
        else begin e = exp_q.pop_front(); if (cyc !== e) $display("FAIL run_start: got cyc %0d want %0d", cyc, e); else pass_cnt++; end
      end
    end
    total_cnt++; if (exp_q.size() != 0) $display("FAIL run_missing: got %0d unissued want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_step();
    run_in = 0;
    for (int k = 0; k < 3; k++) begin
      step_in = 1; exp_q.push_back(cyc + 2);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); step_in = 0;
        if (exec_start_out) begin
          total_cnt++;
          if (exp_q.size() == 0) $display("FAIL step_start: start at cyc %0d want none", cyc);
          else begin e = exp_q.pop_front(); if (cyc !== e) $display("FAIL step_start: got cyc %0d want %0d", cyc, e); else pass_cnt++; end
        end
      end
    end
    total_cnt++; if (exp_q.size() != 0) $display("FAIL step_missing: got %0d unissued want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c;
    c = cyc; step_in = 1; exp_q.push_back(c + 2);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      step_in = (i == 3 || i == 5);
      if (i == 3) exp_q.push_back(c + 7);
      if (exec_start_out) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_start: start at cyc %0d want none", cyc);
        else begin e = exp_q.pop_front(); if (cyc !== e) $display("FAIL b2b_start: got cyc %0d want %0d", cyc, e); else pass_cnt++; end
      end
    end
    total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_missing: got %0d unissued want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tick60_out && n < 150);
    total_cnt++; if (tick60_out !== 1'b1) $display("FAIL %s: tick60 got %b want 1 within 150", name, tick60_out); else pass_cnt++;
  endtask

  task automatic test_timers();
    run_in = 1;
    wait_tick("tmr_sync");
    @(negedge clk); tmr_wr_in = 1; tmr_sel_in = 0; tmr_data_in = 5;
    exp_d = '{4, 3, 2, 1, 0, 0}; exp_b = '{1, 0, 0, 0, 0, 0};
    @(negedge clk); tmr_sel_in = 1; tmr_data_in = 2;
    total_cnt++; if (delay_out !== 8'd5) $display("FAIL tmr_wr_delay: got %0d want 5", delay_out); else pass_cnt++;
    @(negedge clk); tmr_wr_in = 0;
    total_cnt++; if ({beep_out, sound_out} !== {1'b1, 8'd2}) $display("FAIL tmr_wr_sound: got %b/%0d want 1/2", beep_out, sound_out); else pass_cnt++;
    while (exp_d.size() > 0) begin
      wait_tick("tmr_tick");
      @(negedge clk);
      e = exp_d.pop_front();
      total_cnt++; if (delay_out !== 8'(e)) $display("FAIL tmr_delay: got %0d want %0d", delay_out, e); else pass_cnt++;
      e = exp_b.pop_front();
      total_cnt++; if (beep_out !== 1'(e)) $display("FAIL tmr_beep: got %b want %0d", beep_out, e); else pass_cnt++;
    end
  endtask

  task automatic test_write_vs_tick();
    @(negedge clk); tmr_wr_in = 1; tmr_sel_in = 0; tmr_data_in = 3;
    @(negedge clk); tmr_sel_in = 1; tmr_data_in = 4;
    @(negedge clk); tmr_wr_in = 0;
    wait_tick("wr_tick_sync");
    tmr_wr_in = 1; tmr_sel_in = 0; tmr_data_in = 9;
    exp_d.push_back(9); exp_d.push_back(3);
    @(negedge clk); tmr_wr_in = 0;
    e = exp_d.pop_front();
    total_cnt++; if (delay_out !== 8'(e)) $display("FAIL wr_wins_delay: got %0d want %0d", delay_out, e); else pass_cnt++;
    e = exp_d.pop_front();
    total_cnt++; if (sound_out !== 8'(e)) $display("FAIL wr_other_sound: got %0d want %0d", sound_out, e); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    int s, n;
    run_in = 0;
    repeat (8) @(negedge clk);
    auto_done = 0; step_in = 1; exp_q.push_back(cyc + 2);
    n = 0;
    do begin @(negedge clk); step_in = 0; n++; end while (!exec_start_out && n < 10);
    e = exp_q.pop_front();
    total_cnt++; if (cyc !== e) $display("FAIL wdog_start: got cyc %0d want %0d", cyc, e); else pass_cnt++;
    s = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!wdog_err_out && n < 40);
    total_cnt++; if (!wdog_err_out || cyc - s < 16 || cyc - s > 17) $display("FAIL wdog_expire: err %b after %0d cyc want 1 after 16..17", wdog_err_out, cyc - s); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL wdog_busy: got %b want 0", busy_out); else pass_cnt++;
    auto_done = 1; step_in = 1; exp_q.push_back(cyc + 2);
    @(negedge clk); step_in = 0;
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (exec_start_out !== 1'b1 || cyc !== e) $display("FAIL wdog_restep: start %b at cyc %0d want 1 at %0d", exec_start_out, cyc, e); else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++; if (wdog_err_out !== 1'b1) $display("FAIL wdog_sticky: got %b want 1", wdog_err_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    tmr_wr_in = 1; tmr_sel_in = 0; tmr_data_in = 7;
    @(negedge clk); tmr_wr_in = 0;
    auto_done = 0; step_in = 1;
    n = 0;
    do begin @(negedge clk); step_in = 0; n++; end while (!exec_start_out && n < 10);
    @(negedge clk);
    total_cnt++; if (busy_out !== 1'b1 || delay_out !== 8'd7) $display("FAIL rst_pre: busy %b delay %0d want 1/7", busy_out, delay_out); else pass_cnt++;
    rst_in = 1;
    @(negedge clk); rst_in = 0;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else pass_cnt++;
    total_cnt++; if ({delay_out, sound_out, wdog_err_out} !== 17'h0) $display("FAIL rst_state: got %0d/%0d/%b want 0/0/0", delay_out, sound_out, wdog_err_out); else pass_cnt++;
    n = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (exec_start_out) n++; end
    total_cnt++; if (n != 0) $display("FAIL rst_nostart: got %0d starts want 0", n); else pass_cnt++;
    auto_done = 1; step_in = 1; exp_q.push_back(cyc + 2);
    @(negedge clk); step_in = 0;
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if (exec_start_out !== 1'b1 || cyc !== e) $display("FAIL rst_restep: start %b at cyc %0d want 1 at %0d", exec_start_out, cyc, e); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_back_to_back();
    test_timers();
    test_write_vs_tick();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
